// File: rtl/tlb_pkg.sv
// tlb_pkg: shared configuration for the PCID-tagged TLB.
// Holds the geometry defaults (WAYS, SETS, PAGE_SHIFT, PCID_W) and the widths
// derived from them. It also defines the tlb_entry_t record and the tree-PLRU
// victim/update helpers used by tlb_cache.
package tlb_pkg;

  localparam int WAYS       = 8;
  localparam int SETS       = 8;
  localparam int PAGE_SHIFT = 12;
  localparam int PCID_W     = 12;

  localparam int IDX_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int TAG_W  = 64 - PAGE_SHIFT - IDX_W;
  localparam int PPN_W  = 64 - PAGE_SHIFT;
  localparam int PLRU_W = WAYS - 1;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [PCID_W-1:0] pcid;
    logic [PPN_W-1:0]  ppn;
  } tlb_entry_t;

  // The tree is stored heap-style: node n has children 2n+1 (lower half) and
  // 2n+2 (upper half). A bit value of 0 sends the victim search to the lower
  // half, so a bit equals the way-number bit at that level of the tree.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    int node;
    logic [WAY_W-1:0] way;
    node = 0;
    way  = '0;
    for (int l = 0; l < WAY_W; l++) begin
      way[WAY_W-1-l] = bits[node];
      node = 2 * node + 1 + int'(bits[node]);
    end
    return way;
  endfunction

  // Every node on the accessed way's path is made to point at the other half.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  way);
    int node;
    logic [PLRU_W-1:0] nxt;
    node = 0;
    nxt  = bits;
    for (int l = 0; l < WAY_W; l++) begin
      nxt[node] = ~way[WAY_W-1-l];
      node = 2 * node + 1 + int'(way[WAY_W-1-l]);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tlb_cache_if.sv
// tlb_cache_if: request/response bundle between address generation and the TLB.
//   master: drives insert, va, pa, pcid; receives o_addr, hit, miss, stat_*.
//   slave : the TLB side (opposite directions).
interface tlb_cache_if;

  logic                      insert;
  logic [63:0]               va;
  logic [63:0]               pa;
  logic [tlb_pkg::PCID_W-1:0] pcid;
  logic [63:0]               o_addr;
  logic                      hit;
  logic                      miss;
  logic [63:0]               stat_hit;
  logic [63:0]               stat_miss;
  logic [63:0]               stat_prefetch;

  modport master (
    output insert, va, pa, pcid,
    input  o_addr, hit, miss, stat_hit, stat_miss, stat_prefetch
  );

  modport slave (
    input  insert, va, pa, pcid,
    output o_addr, hit, miss, stat_hit, stat_miss, stat_prefetch
  );

endinterface

// File: rtl/tlb_cache_pmu.sv
// tlb_pmu: hit / miss / insert event counters for tlb_cache.
// The module only exists when TLB_PMU_EN is defined.
//   clk, shutdown_n   : clock, asynchronous active-low clear
//   i_hit, i_miss     : registered lookup result of the TLB
//   i_insert          : insert request of the current cycle
//   o_stat_hit/miss/prefetch : 64-bit wrapping counters
`ifdef TLB_PMU_EN
module tlb_pmu (
  input  logic        clk,
  input  logic        shutdown_n,
  input  logic        i_hit,
  input  logic        i_miss,
  input  logic        i_insert,
  output logic [63:0] o_stat_hit,
  output logic [63:0] o_stat_miss,
  output logic [63:0] o_stat_prefetch
);

  logic [63:0] r_hit_cnt;
  logic [63:0] r_miss_cnt;
  logic [63:0] r_ins_cnt;

  always_ff @(posedge clk or negedge shutdown_n) begin
    if (!shutdown_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_ins_cnt  <= '0;
    end else begin
      if (i_hit)    r_hit_cnt  <= r_hit_cnt + 64'd1;
      if (i_miss)   r_miss_cnt <= r_miss_cnt + 64'd1;
      if (i_insert) r_ins_cnt  <= r_ins_cnt + 64'd1;
    end
  end

  assign o_stat_hit      = r_hit_cnt;
  assign o_stat_miss     = r_miss_cnt;
  assign o_stat_prefetch = r_ins_cnt;

endmodule
`endif

// File: rtl/tlb_cache.sv
// tlb_cache: 8-set x 8-way PCID-tagged TLB, 4 KiB pages, one lookup per clock.
//   clk        : rising-edge clock
//   shutdown_n : asynchronous active-low reset; clears valid bits, PLRU state,
//                result registers and counters
//   bus        : tlb_cache_if.slave (insert/va/pa/pcid in; o_addr/hit/miss and
//                stat_* out)
// Optional PMU counters are built when TLB_PMU_EN is defined; otherwise the
// stat_* outputs read 0.
module tlb_cache
  import tlb_pkg::*;
(
  input  logic        clk,
  input  logic        shutdown_n,
  tlb_cache_if.slave  bus
);

  logic [WAYS-1:0]   r_valid [SETS];
  logic [PLRU_W-1:0] r_plru  [SETS];
  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  logic [PCID_W-1:0] r_pcid  [SETS][WAYS];
  logic [PPN_W-1:0]  r_ppn   [SETS][WAYS];

  logic [63:0] r_addr;
  logic        r_hit;
  logic        r_miss;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  tlb_entry_t       w_set [WAYS];
  logic             w_match_any;
  logic [WAY_W-1:0] w_match_way;
  logic             w_free_any;
  logic [WAY_W-1:0] w_free_way;
  logic [WAY_W-1:0] w_ins_way;
  logic [PPN_W-1:0] w_ppn;

  assign w_idx = bus.va[PAGE_SHIFT +: IDX_W];
  assign w_tag = bus.va[63 -: TAG_W];

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      w_set[w].valid = r_valid[w_idx][w];
      w_set[w].tag   = r_tag[w_idx][w];
      w_set[w].pcid  = r_pcid[w_idx][w];
      w_set[w].ppn   = r_ppn[w_idx][w];
    end
  end

  // Inserts never create duplicates, so at most one way can match and the
  // last-match-wins encoder below is unambiguous.
  always_comb begin
    w_match_any = 1'b0;
    w_match_way = '0;
    w_free_any  = 1'b0;
    w_free_way  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_set[w].valid && (w_set[w].tag == w_tag) && (w_set[w].pcid == bus.pcid)) begin
        w_match_any = 1'b1;
        w_match_way = WAY_W'(w);
      end
    end
    // Descending scan so the lowest invalid way is the one left selected.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_set[w].valid) begin
        w_free_any = 1'b1;
        w_free_way = WAY_W'(w);
      end
    end
    w_ppn = w_set[w_match_way].ppn;
    if (w_match_any)     w_ins_way = w_match_way;
    else if (w_free_any) w_ins_way = w_free_way;
    else                 w_ins_way = plru_victim(r_plru[w_idx]);
  end

  // Control and result state: cleared by shutdown_n.
  always_ff @(posedge clk or negedge shutdown_n) begin
    if (!shutdown_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
      r_addr <= '0;
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
    end else if (bus.insert) begin
      r_valid[w_idx][w_ins_way] <= 1'b1;
      r_plru[w_idx]             <= plru_touch(r_plru[w_idx], w_ins_way);
      r_addr <= '0;
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
    end else begin
      r_hit  <= w_match_any;
      r_miss <= ~w_match_any;
      r_addr <= w_match_any ? {w_ppn, bus.va[PAGE_SHIFT-1:0]} : 64'd0;
      if (w_match_any) r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_match_way);
    end
  end

  // Translation payload: only meaningful behind a valid bit, so never reset.
  always_ff @(posedge clk) begin
    if (bus.insert) begin
      r_tag[w_idx][w_ins_way]  <= w_tag;
      r_pcid[w_idx][w_ins_way] <= bus.pcid;
      r_ppn[w_idx][w_ins_way]  <= bus.pa[63:PAGE_SHIFT];
    end
  end

  assign bus.o_addr = r_addr;
  assign bus.hit    = r_hit;
  assign bus.miss   = r_miss;

  logic [63:0] w_stat_hit;
  logic [63:0] w_stat_miss;
  logic [63:0] w_stat_prefetch;

`ifdef TLB_PMU_EN
  tlb_pmu u_pmu (
    .clk             (clk),
    .shutdown_n      (shutdown_n),
    .i_hit           (r_hit),
    .i_miss          (r_miss),
    .i_insert        (bus.insert),
    .o_stat_hit      (w_stat_hit),
    .o_stat_miss     (w_stat_miss),
    .o_stat_prefetch (w_stat_prefetch)
  );
`else
  assign w_stat_hit      = '0;
  assign w_stat_miss     = '0;
  assign w_stat_prefetch = '0;
`endif

  assign bus.stat_hit      = w_stat_hit;
  assign bus.stat_miss     = w_stat_miss;
  assign bus.stat_prefetch = w_stat_prefetch;

endmodule

// File: tb/tb_tlb_cache.sv
// tb_tlb_cache: directed self-checking bench for tlb_cache.
module tb_tlb_cache;
  import tlb_pkg::*;

  logic clk = 1'b0;
  logic shutdown_n = 1'b0;
  always #5 clk = ~clk;

  tlb_cache_if bus();

  tlb_cache dut (
    .clk        (clk),
    .shutdown_n (shutdown_n),
    .bus        (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Expected counter values, advanced from the expected registered results.
  logic [63:0] m_hit, m_miss, m_ins;
  logic        p_hit, p_miss;

  localparam logic [63:0] VA_A = 64'hFFFF_FFFF_FFFF_FFF1;

  function automatic logic [63:0] mkva(input int set, input int tag, input logic [11:0] off);
    return (64'(tag) << 15) | (64'(set) << 12) | 64'(off);
  endfunction

  function automatic logic [63:0] mkpa(input int k);
    return 64'h0000_0070_0000_0000 + (64'(k) << 12);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_stats(input string tag);
`ifdef TLB_PMU_EN
    chk({tag, ".stat_hit"},      bus.stat_hit,      m_hit);
    chk({tag, ".stat_miss"},     bus.stat_miss,     m_miss);
    chk({tag, ".stat_prefetch"}, bus.stat_prefetch, m_ins);
`else
    chk({tag, ".stat_hit"},      bus.stat_hit,      64'd0);
    chk({tag, ".stat_miss"},     bus.stat_miss,     64'd0);
    chk({tag, ".stat_prefetch"}, bus.stat_prefetch, 64'd0);
`endif
  endtask

  // One clock: advance the counter model, then check results 1ns after the edge.
  task automatic cyc(input string tag, input logic eh, input logic em, input logic [63:0] ea);
    @(posedge clk);
    m_hit  += 64'(p_hit);
    m_miss += 64'(p_miss);
    if (bus.insert) m_ins += 64'd1;
    #1;
    chk({tag, ".hit"},    64'(bus.hit),  64'(eh));
    chk({tag, ".miss"},   64'(bus.miss), 64'(em));
    chk({tag, ".o_addr"}, bus.o_addr,    ea);
    chk_stats(tag);
    p_hit  = eh;
    p_miss = em;
  endtask

  task automatic do_ins(input logic [63:0] va, input logic [PCID_W-1:0] pcid,
                        input logic [63:0] pa, input string tag);
    bus.insert = 1'b1;
    bus.va     = va;
    bus.pcid   = pcid;
    bus.pa     = pa;
    cyc(tag, 1'b0, 1'b0, 64'd0);
    bus.insert = 1'b0;
  endtask

  task automatic do_lk(input logic [63:0] va, input logic [PCID_W-1:0] pcid,
                       input logic eh, input logic [63:0] ea, input string tag);
    bus.insert = 1'b0;
    bus.va     = va;
    bus.pcid   = pcid;
    cyc(tag, eh, ~eh, ea);
  endtask

  task automatic model_clear();
    m_hit  = '0;
    m_miss = '0;
    m_ins  = '0;
    p_hit  = 1'b0;
    p_miss = 1'b0;
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    bus.insert = 1'b0;
    bus.va     = '0;
    bus.pa     = '0;
    bus.pcid   = '0;
    model_clear();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.hit",    64'(bus.hit),  64'd0);
    chk("rst.miss",   64'(bus.miss), 64'd0);
    chk("rst.o_addr", bus.o_addr,    64'd0);
    chk_stats("rst");
    shutdown_n = 1'b1;

    // Cold lookup misses
    do_lk(VA_A, 12'd0, 1'b0, 64'd0, "cold0");
    do_lk(VA_A, 12'd0, 1'b0, 64'd0, "cold1");

    // Insert held for two cycles occupies one way
    do_ins(VA_A, 12'd0, 64'h0000_0000_ABCD_5000, "insA0");
    do_ins(VA_A, 12'd0, 64'h0000_0000_ABCD_5000, "insA1");
    do_lk(VA_A, 12'd0, 1'b1, 64'h0000_0000_ABCD_5FF1, "hitA");
    chk("set7.valid", 64'(dut.r_valid[7]), 64'h01);

    // PCID isolation
    do_lk(VA_A, 12'd1, 1'b0, 64'd0, "pcid1");
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 5; c++) begin
        if (s % 2 == 0) do_lk(VA_A, 12'd0, 1'b1, 64'h0000_0000_ABCD_5FF1, "alt.p0");
        else            do_lk(VA_A, 12'd1, 1'b0, 64'd0, "alt.p1");
      end
    end

    // Fill set 0 in order, then a ninth tag evicts way 0
    for (int k = 1; k <= 8; k++) do_ins(mkva(0, k, 12'h000), 12'd0, mkpa(k), "fill0");
    chk("set0.valid", 64'(dut.r_valid[0]), 64'hFF);
    do_ins(mkva(0, 9, 12'h000), 12'd0, mkpa(9), "fill0.9");
    do_lk(mkva(0, 1, 12'h0AB), 12'd0, 1'b0, 64'd0, "evict.t1");
    do_lk(mkva(0, 9, 12'h0AB), 12'd0, 1'b1, mkpa(9) | 64'h0AB, "keep.t9");
    for (int k = 2; k <= 8; k++)
      do_lk(mkva(0, k, 12'h0AB), 12'd0, 1'b1, mkpa(k) | 64'h0AB, "keep.tk");

    // Re-insert existing entry updates it in place
    do_ins(mkva(0, 5, 12'h000), 12'd0, 64'h0000_0000_1234_0000, "reins5");
    do_lk(mkva(0, 5, 12'h0AB), 12'd0, 1'b1, 64'h0000_0000_1234_00AB, "upd.t5");
    do_lk(mkva(0, 9, 12'h0AB), 12'd0, 1'b1, mkpa(9) | 64'h0AB, "post.t9");
    for (int k = 2; k <= 8; k++)
      if (k != 5) do_lk(mkva(0, k, 12'h0AB), 12'd0, 1'b1, mkpa(k) | 64'h0AB, "post.tk");

    // Asynchronous reset in the middle of a cycle
    #3;
    shutdown_n = 1'b0;
    #1;
    chk("arst.hit",    64'(bus.hit),  64'd0);
    chk("arst.miss",   64'(bus.miss), 64'd0);
    chk("arst.o_addr", bus.o_addr,    64'd0);
    model_clear();
    chk_stats("arst");
    @(posedge clk);
    #1;
    shutdown_n = 1'b1;
    do_lk(mkva(0, 3, 12'h0AB), 12'd0, 1'b0, 64'd0, "gone.t3");
    do_lk(VA_A, 12'd0, 1'b0, 64'd0, "gone.A");

    // PLRU follows hits: fill set 1, hit way 0, ninth insert evicts way 4
    for (int k = 1; k <= 8; k++) do_ins(mkva(1, k, 12'h000), 12'd0, mkpa(k), "fill1");
    do_lk(mkva(1, 1, 12'h010), 12'd0, 1'b1, mkpa(1) | 64'h010, "plru.t1");
    do_ins(mkva(1, 9, 12'h000), 12'd0, mkpa(9), "fill1.9");
    do_lk(mkva(1, 5, 12'h010), 12'd0, 1'b0, 64'd0, "plru.evict5");
    do_lk(mkva(1, 1, 12'h010), 12'd0, 1'b1, mkpa(1) | 64'h010, "plru.keep1");
    do_lk(mkva(1, 9, 12'h010), 12'd0, 1'b1, mkpa(9) | 64'h010, "plru.keep9");
    do_lk(mkva(1, 4, 12'h010), 12'd0, 1'b1, mkpa(4) | 64'h010, "plru.keep4");
    do_lk(mkva(1, 6, 12'h010), 12'd0, 1'b1, mkpa(6) | 64'h010, "plru.keep6");
    do_lk(mkva(1, 6, 12'h010), 12'd0, 1'b1, mkpa(6) | 64'h010, "plru.tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlb_cache.md
Name: tlb_cache

Overview:
- 8-set x 8-way set-associative TLB, tagged by PCID.
- Translates a 64-bit virtual address to a 64-bit physical address using 4 KiB pages, one lookup per clock.
- Software-visible insert and flush of entries; tree-PLRU replacement within each set.
- Optional PMU counts hits, misses and inserts. Sits between the address-generation stage and the memory pipeline.

Parameters:
- WAYS, 8, ways per set; power of two; PLRU tree has WAYS-1 bits.
- SETS, 8, sets; power of two; index = va[PAGE_SHIFT +: log2(SETS)].
- PAGE_SHIFT, 12, page offset width.
- PCID_W, 12, process-context identifier width.

Ports:
- clk  in  1  rising-edge clock.
- shutdown_n  in  1  asynchronous active-low reset/flush of whole TLB and PMU.
- insert  in  1  write {va, pcid} -> pa this cycle; no lookup result is produced this cycle.
- va  in  64  virtual address.
- pa  in  64  physical address for insert (bits [PAGE_SHIFT-1:0] ignored).
- pcid  in  PCID_W  context id for lookup/insert.
- o_addr  out  64  translated address, registered.
- hit  out  1  registered lookup hit.
- miss  out  1  registered lookup miss.
- stat_hit  out  64  hit count.
- stat_miss  out  64  miss count.
- stat_prefetch  out  64  insert count.

Behaviour:
- Entry fields: valid, tag = va[63:PAGE_SHIFT+3] (49 bits), pcid, ppn = pa[63:PAGE_SHIFT]. Set index = va[14:12].
- Reset (shutdown_n=0, async):
  - All valid bits, all PLRU bits, and all counters become 0.
  - o_addr=0, hit=0, miss=0.
  - Tag/pcid/ppn storage need not be cleared.
  - Reset can arrive at any time; the first edge after release behaves as a normal cycle.
- Lookup (insert=0), latency 1 cycle:
  - Every rising edge compares all ways of the indexed set; a way matches when valid && tag && pcid all match.
  - On a match, the next cycle shows hit=1, miss=0, o_addr={ppn, va[11:0]}.
  - Otherwise the next cycle shows hit=0, miss=1, o_addr=0.
  - A different pcid never hits. At most one way may match; inserts guarantee this.
- Insert (insert=1):
  - If the set already has a matching entry (valid, same tag and pcid), its ppn is overwritten in place.
  - Otherwise, the lowest-index invalid way is written.
  - Otherwise, the PLRU victim is written. The entry is written with valid=1.
  - The result registers show hit=0, miss=0, o_addr=0 the following cycle.
  - Holding insert for N cycles with the same inputs occupies one way only.
- PLRU:
  - Binary tree, per set. On every lookup hit and every insert, the bits on the accessed way's path are set to point away from it.
  - Bit convention: 0 = victim in lower half.
  - Misses do not update PLRU. PLRU is unaffected by other sets.
- Lookup and insert are mutually exclusive by construction: insert takes priority, and no lookup occurs in that cycle.

Optional Feature:
- Macro TLB_PMU_EN.
- When defined:
  - stat_hit and stat_miss increment by 1 on each clock edge where the registered hit or miss output is 1.
  - stat_prefetch increments by 1 on each edge with insert=1.
  - All three counters are 64-bit, wrap modulo 2^64, and are cleared by shutdown_n.
- When undefined: the stat_* outputs are tied to 0 and no counter flops exist.

Decomposition:
- Package tlb_pkg holds:
  - The parameter defaults.
  - The derived widths (IDX_W, TAG_W, PPN_W).
  - The tlb_entry_t struct {valid, tag, pcid, ppn}.
  - The PLRU victim/update helper functions.
- One sub-module, tlb_pmu (the three counters), is instantiated under TLB_PMU_EN.

Test Plan:
- Reset, then lookup va=64'hFFFF_FFFF_FFFF_FFF1, pcid=0 -> next cycle miss=1, hit=0, o_addr=0; stat_miss=1.
- Insert va=64'hFFFF_FFFF_FFFF_FFF1, pcid=0, pa=64'h0000_0000_ABCD_5000 for 2 cycles, then look up the same va with pcid=0 -> hit=1, o_addr=64'h0000_0000_ABCD_5FF1.
  - Only one valid way in set 7.
  - stat_prefetch=2.
- Same va with pcid=1 -> miss=1. Alternating pcid 0/1 every 5 cycles -> hit/miss alternate accordingly.
- Insert 8 distinct tags into set 0 (ways 0..7 in order), then insert a 9th tag -> way 0 is evicted.
  - Lookup of the first tag misses; lookups of the 9th tag and tags 2..8 hit.
- Re-insert an existing {va, pcid} with new pa=64'h1234_0000 -> same way is updated; lookup returns 64'h1234_0xxx with the va offset.
- Assert shutdown_n=0 mid-sequence -> outputs and counters are 0 immediately; previously inserted translations miss after release.
